// File: rtl/sigma_np_acc.sv
// N-point sample accumulator (N = 2**LOG2N): block or sliding-window sum of strobed samples,
// with sign-magnitude / two's-complement input and optional mean output.
module sigma_np_acc #(
  parameter int DW    = 8,
  parameter int LOG2N = 4,
  parameter int OW    = DW + LOG2N
) (
  input  logic          clk,
  input  logic          res,
  input  logic          mode,
  input  logic          fmt_sm,
  input  logic          avg_en,
  input  logic [DW-1:0] data_in,
  input  logic          syn_in,
  output logic [OW-1:0] data_out,
  output logic          syn_out
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_LAST  = LOG2N'(N - 1);
  localparam logic [LOG2N:0]   FILL_FULL = (LOG2N + 1)'(N);

  logic             syn_d_q,    syn_d_d;
  logic             mode_q,     mode_d;
  logic [OW-1:0]    acc_q,      acc_d;
  logic [LOG2N-1:0] cnt_q,      cnt_d;
  logic [LOG2N:0]   fill_q,     fill_d;
  logic [LOG2N-1:0] wp_q,       wp_d;
  logic [OW-1:0]    data_out_q, data_out_d;
  logic             syn_out_q,  syn_out_d;

  // Converted samples always fit in DW bits, so the window stores them unextended.
  logic [DW-1:0]    win_q [N];
  logic             win_we;

  logic             pulse;
  logic [DW-1:0]    mag;
  logic [DW-1:0]    x_dw;
  logic [OW-1:0]    x_ext;
  logic [OW-1:0]    old_ext;
  logic [OW-1:0]    blk_sum;
  logic [OW-1:0]    sld_sum;

  function automatic logic [OW-1:0] scale(input logic [OW-1:0] s, input logic avg);
    if (avg) return OW'($signed(s) >>> LOG2N);
    return s;
  endfunction

  always_comb begin
    pulse   = syn_in & ~syn_d_q;
    mag     = {1'b0, data_in[DW-2:0]};
    x_dw    = data_in;
    if (fmt_sm) x_dw = data_in[DW-1] ? (~mag + 1'b1) : mag;
    x_ext   = {{LOG2N{x_dw[DW-1]}}, x_dw};
    old_ext = '0;
    if (fill_q == FILL_FULL) old_ext = {{LOG2N{win_q[wp_q][DW-1]}}, win_q[wp_q]};
    blk_sum = acc_q + x_ext;
    sld_sum = acc_q + x_ext - old_ext;
  end

  always_comb begin
    syn_d_d    = syn_in;
    mode_d     = mode;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    wp_d       = wp_q;
    data_out_d = data_out_q;
    syn_out_d  = 1'b0;
    win_we     = 1'b0;
    if (mode != mode_q) begin
      // Mode switch flushes the window and swallows any strobe in this cycle.
      acc_d  = '0;
      cnt_d  = '0;
      fill_d = '0;
      wp_d   = '0;
    end else if (pulse && !mode) begin
      if (cnt_q == CNT_LAST) begin
        data_out_d = scale(blk_sum, avg_en);
        syn_out_d  = 1'b1;
        acc_d      = '0;
        cnt_d      = '0;
      end else begin
        acc_d = blk_sum;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (pulse && mode) begin
      win_we = 1'b1;
      wp_d   = wp_q + 1'b1;
      acc_d  = sld_sum;
      if (fill_q != FILL_FULL) fill_d = fill_q + 1'b1;
      if (fill_d == FILL_FULL) begin
        data_out_d = scale(sld_sum, avg_en);
        syn_out_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      syn_d_q    <= 1'b1;
      mode_q     <= mode;
      acc_q      <= '0;
      cnt_q      <= '0;
      fill_q     <= '0;
      wp_q       <= '0;
      data_out_q <= '0;
      syn_out_q  <= 1'b0;
    end else begin
      syn_d_q    <= syn_d_d;
      mode_q     <= mode_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      wp_q       <= wp_d;
      data_out_q <= data_out_d;
      syn_out_q  <= syn_out_d;
    end
  end

  // Window storage needs no reset: entries are only read once fill reaches N.
  always_ff @(posedge clk) begin
    if (!res && win_we) win_q[wp_q] <= x_dw;
  end

  assign data_out = data_out_q;
  assign syn_out  = syn_out_q;

endmodule

// File: tb/tb_sigma_np_acc.sv
// Self-checking bench for sigma_np_acc: block-mode vector table, sliding-window runs,
// strobe/mode/reset corner sequences, all results matched through an expected queue.
module tb_sigma_np_acc;

  localparam int DW = 8;
  localparam int LOG2N = 4;
  localparam int OW = DW + LOG2N;
  localparam int N = 16;

  logic          clk;
  logic          res;
  logic          mode;
  logic          fmt_sm;
  logic          avg_en;
  logic [DW-1:0] data_in;
  logic          syn_in;
  logic [OW-1:0] data_out;
  logic          syn_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [OW-1:0] last_exp;
  logic [OW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  sigma_np_acc #(.DW(DW), .LOG2N(LOG2N)) dut (
    .clk(clk), .res(res), .mode(mode), .fmt_sm(fmt_sm), .avg_en(avg_en),
    .data_in(data_in), .syn_in(syn_in), .data_out(data_out), .syn_out(syn_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // scoreboard: every syn_out pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!res && syn_out) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_syn_out: got data_out=%0h at cyc %0d, expected no output", data_out, cyc);
      end else begin
        check("result", int'(data_out), int'(exp_q.pop_front()));
        check("latency_cyc", cyc, exp_cyc_q.pop_front());
      end
    end
  end

  // driver: one strobe held hi clocks, then at least lo low clocks
  task automatic send(input logic [DW-1:0] d, input int hi, input int lo,
                      input bit expect_out, input logic [OW-1:0] e);
    @(negedge clk);
    if (expect_out) begin
      exp_q.push_back(e);
      exp_cyc_q.push_back(cyc + 1);
      last_exp = e;
    end
    data_in = d;
    syn_in  = 1'b1;
    repeat (hi) @(negedge clk);
    syn_in = 1'b0;
    repeat (lo - 1) @(negedge clk);
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_hold"}, int'(data_out), int'(last_exp));
    check({name, "_syn_idle"}, int'(syn_out), 0);
  endtask

  function automatic int conv(input logic [DW-1:0] d, input logic sm);
    if (sm) return d[DW-1] ? -int'(d[DW-2:0]) : int'(d[DW-2:0]);
    return int'($signed(d));
  endfunction

  task automatic set_mode(input logic m);
    @(negedge clk);
    mode = m;
    @(negedge clk);
  endtask

  typedef struct {
    logic          sm;
    logic          avg;
    logic [DW-1:0] d_a;
    logic [DW-1:0] d_b;
    int            n_a;
    logic [OW-1:0] exp;
  } blk_vec_t;

  blk_vec_t vecs[9];
  int win[$];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 8'h05, 8'h05, 16, 12'h050};
    vecs[1] = '{1'b1, 1'b0, 8'h83, 8'h83, 16, 12'hFD0};
    vecs[2] = '{1'b1, 1'b0, 8'h80, 8'h80, 16, 12'h000};
    vecs[3] = '{1'b1, 1'b0, 8'h05, 8'h85,  8, 12'h000};
    vecs[4] = '{1'b0, 1'b0, 8'h80, 8'h80, 16, 12'h800};
    vecs[5] = '{1'b0, 1'b1, 8'h80, 8'h80, 16, 12'hF80};
    vecs[6] = '{1'b0, 1'b1, 8'h7F, 8'h7F, 16, 12'h07F};
    vecs[7] = '{1'b0, 1'b1, 8'h00, 8'hFF, 15, 12'hFFF};
    vecs[8] = '{1'b1, 1'b1, 8'hFF, 8'h7F,  8, 12'h000};

    res = 1'b1; mode = 1'b0; fmt_sm = 1'b0; avg_en = 1'b0;
    data_in = '0; syn_in = 1'b0; last_exp = '0;
    repeat (3) @(negedge clk);
    check("reset_data_out", int'(data_out), 0);
    check("reset_syn_out", int'(syn_out), 0);
    res = 1'b0;
    @(negedge clk);

    // block-mode vector table
    for (int v = 0; v < 9; v++) begin
      fmt_sm = vecs[v].sm;
      avg_en = vecs[v].avg;
      for (int k = 0; k < N; k++)
        send((k < vecs[v].n_a) ? vecs[v].d_a : vecs[v].d_b, 1, 1, k == N - 1, vecs[v].exp);
      drain($sformatf("blk%0d", v));
    end

    // strobe held high for 5 clocks counts as one sample
    fmt_sm = 1'b0; avg_en = 1'b0;
    for (int k = 0; k < N; k++)
      send(8'h03, (k == 2) ? 5 : 1, (k == 5) ? 3 : 1, k == N - 1, 12'h030);
    drain("held_strobe");

    // mode toggle after 7 samples flushes; strobe in the switching cycle is dropped
    for (int k = 0; k < 7; k++) send(8'h10, 1, 1, 1'b0, '0);
    @(negedge clk);
    mode = 1'b1; data_in = 8'h40; syn_in = 1'b1;
    @(negedge clk);
    syn_in = 1'b0;
    set_mode(1'b0);
    for (int k = 0; k < N; k++) send(8'h01, 1, 1, k == N - 1, 12'h010);
    drain("mode_flush");

    // sliding mode, samples 1..20: window sum of last 16 = 16*i - 120
    set_mode(1'b1);
    for (int i = 1; i <= 20; i++)
      send(DW'(i), 1, 1, i >= N, OW'(16 * i - 120));
    drain("slide_ramp");

    // sliding mode, random samples/format/averaging against a window model
    set_mode(1'b0);
    set_mode(1'b1);
    win.delete();
    for (int i = 0; i < 40; i++) begin
      logic [DW-1:0] d;
      int sum;
      d = DW'($urandom_range(0, 255));
      fmt_sm = 1'($urandom_range(0, 1));
      avg_en = 1'($urandom_range(0, 1));
      win.push_back(conv(d, fmt_sm));
      if (win.size() > N) void'(win.pop_front());
      sum = 0;
      foreach (win[j]) sum += win[j];
      if (avg_en) sum = sum >>> LOG2N;
      send(d, 1, $urandom_range(1, 2), win.size() == N, OW'(sum));
    end
    drain("slide_rand");

    // reset mid-window; strobe high across reset release gives no sample
    set_mode(1'b0);
    fmt_sm = 1'b0; avg_en = 1'b0;
    for (int k = 0; k < 10; k++) send(8'h07, 1, 1, 1'b0, '0);
    @(negedge clk);
    res = 1'b1; syn_in = 1'b1;
    @(negedge clk);
    check("midres_data_out", int'(data_out), 0);
    check("midres_syn_out", int'(syn_out), 0);
    last_exp = '0;
    res = 1'b0;
    @(negedge clk);
    syn_in = 1'b0;
    for (int k = 0; k < N; k++) send(8'h02, 1, 1, k == N - 1, 12'h020);
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
